crc_engine_param: RTL
=====================

Name: crc_engine_param

Overview:
Parametrised serial CRC engine. It is the next generation of the LAB_1 CRC sequencer and has the LFSR built in. Messages arrive as one or more DATA_W-bit words over a valid/ready handshake, are shifted MSB-first at one bit per CLK, and the block returns a CRC_W-bit result over a second valid/ready handshake. It adds multi-word messages, a configurable polynomial/init/final-XOR, an optional zero-augmentation mode and a synchronous abort.

Parameters:
CRC_W, 16, CRC register width (4..32)
DATA_W, 16, input word width (1..64)
POLY, 16'h1021, generator polynomial, implicit x^CRC_W term omitted
INIT, 16'hFFFF, CRC register value at start of each message
XOR_OUT, 16'h0000, XORed into the result at output
AUGMENT, 0, 0 = direct LFSR; 1 = data shifted into LSB, then CRC_W zero bits appended

Ports:
CLK  input  1  clock, all state on rising edge
RESET_N  input  1  asynchronous active-low reset
CLEAR  input  1  synchronous abort: discard current message, return to IDLE
IN_DATA  input  DATA_W  message word, MSB transmitted first
IN_LAST  input  1  qualifies IN_DATA as final word of message
IN_VALID  input  1  IN_DATA/IN_LAST valid
IN_READY  output  1  engine can accept a word this cycle
OUT_CRC  output  CRC_W  final CRC (crc ^ XOR_OUT)
OUT_VALID  output  1  OUT_CRC valid, held until accepted
OUT_READY  input  1  consumer accepts OUT_CRC
BUSY  output  1  high in any state other than IDLE with no message open

Behaviour:
- Reset (RESET_N low, any time, including mid-message): state=IDLE, crc=INIT, bit counter=0, shift buffer=0, msg_open=0. Outputs: IN_READY=1 once reset deasserts, OUT_VALID=0, OUT_CRC=0, BUSY=0.
- States: IDLE, SHIFT_DATA, SHIFT_ZEROS (only when AUGMENT=1), DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY: latch IN_DATA into the buffer and IN_LAST into a flag, clear the counter, go to SHIFT_DATA.
  - If msg_open=0 at acceptance, load crc=INIT and set msg_open=1.
- SHIFT_DATA:
  - IN_READY=0. Each cycle, b = buffer MSB, then shift buffer left.
  - Update (AUGMENT=0): fb = crc[CRC_W-1]^b; crc = {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
  - Update (AUGMENT=1): fb = crc[CRC_W-1]; crc = {crc[CRC_W-2:0],b} ^ (fb ? POLY : 0).
  - Takes exactly DATA_W cycles. Then: last flag=0 -> IDLE (message stays open). Last flag=1 -> SHIFT_ZEROS if AUGMENT, else DONE.
- SHIFT_ZEROS: AUGMENT update with b=0 for exactly CRC_W cycles, then DONE.
- DONE:
  - OUT_VALID=1, OUT_CRC=crc^XOR_OUT, both stable until OUT_READY.
  - On OUT_VALID&OUT_READY: OUT_VALID=0 next cycle, msg_open=0, go to IDLE.
  - IN_READY=0 while in DONE.
- Throughput/latency:
  - A word accepted at edge t gives IN_READY=1 again at t+DATA_W+1.
  - A last word accepted at t gives OUT_VALID at t+DATA_W+1 (AUGMENT=0) or t+DATA_W+CRC_W+1 (AUGMENT=1).
  - Minimum gap between messages: 1 cycle in IDLE after output acceptance.
- CLEAR:
  - Priority over all handshakes in the same cycle. Next state IDLE, crc=INIT, msg_open=0, OUT_VALID=0. No CRC is produced for the aborted message.
  - A simultaneous IN_VALID is dropped.
- IN_VALID is ignored when IN_READY=0; the source must hold the word until accepted.
- OUT_READY is ignored when OUT_VALID=0.
- Counter width is $clog2(max(DATA_W,CRC_W)+1). The counter never wraps: it resets to 0 on every state entry.
- Parameters are truncated to CRC_W bits. AUGMENT=1 with INIT=0 gives the same result as AUGMENT=0 with INIT=0.

Test Plan:
- CRC-16/CCITT-FALSE (defaults, DATA_W=8): words 0x31..0x39, IN_LAST on 0x39 -> OUT_CRC=16'h29B1; OUT_VALID rises 9 cycles after the last acceptance.
- XMODEM (INIT=0, DATA_W=8): same nine bytes -> 16'h31C3. Repeat with AUGMENT=1 -> 16'h31C3, OUT_VALID 25 cycles after the last acceptance.
- DATA_W=16, INIT=0: single word 16'h0001 with IN_LAST -> 16'h1021. Single word 16'h0000 -> 16'h0000.
- Backpressure: hold OUT_READY=0 for 20 cycles -> OUT_VALID and OUT_CRC stay stable and IN_READY=0 throughout. Assert OUT_READY -> OUT_VALID drops next cycle; the next message starts from INIT.
- CLEAR after 3 of 9 bytes, then resend the full "123456789" -> 16'h29B1. Async reset pulse mid SHIFT_DATA -> IN_READY=1, OUT_VALID=0, BUSY=0; resent message gives the correct CRC.
- Handshake abuse: IN_VALID held high while IN_READY=0 -> no extra words absorbed, and the word count and CRC match the directed reference values.

Source files
------------

// File: rtl/crc_engine_param.sv
// crc_engine_param: serial CRC engine, one message bit per clock, MSB first.
// Words enter on a valid/ready handshake and may be chained into one message
// until a word flagged IN_LAST closes it; the result leaves on a second
// valid/ready handshake.
module crc_engine_param #(
    parameter int          CRC_W   = 16,
    parameter int          DATA_W  = 16,
    parameter logic [63:0] POLY    = 64'h1021,
    parameter logic [63:0] INIT    = 64'hFFFF,
    parameter logic [63:0] XOR_OUT = 64'h0000,
    parameter int          AUGMENT = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CLEAR,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_LAST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [CRC_W-1:0]  OUT_CRC,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              BUSY
);

    // Configuration values are only meaningful in their low CRC_W bits.
    localparam logic [CRC_W-1:0] POLY_T = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_T = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_T  = XOR_OUT[CRC_W-1:0];

    // The bit counter only has to reach the longer of the two shift phases.
    localparam int MAX_W = (DATA_W > CRC_W) ? DATA_W : CRC_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] ZERO_LAST = CNT_W'(CRC_W - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SHIFT_DATA  = 2'd1,
        SHIFT_ZEROS = 2'd2,
        DONE        = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [CRC_W-1:0]  crc, crc_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [DATA_W-1:0] shbuf, shbuf_d;
    logic              last_flag, last_d;
    logic              msg_open, open_d;

    // One LFSR step. The direct form folds the message bit into the feedback;
    // the augmented form shifts the bit into the LSB and relies on CRC_W
    // trailing zero bits to flush it through.
    function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] c,
                                                   input logic b);
        logic fb;
        if (AUGMENT == 0) begin
            fb = c[CRC_W-1] ^ b;
            return {c[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb}} & POLY_T);
        end else begin
            fb = c[CRC_W-1];
            return {c[CRC_W-2:0], b} ^ ({CRC_W{fb}} & POLY_T);
        end
    endfunction

    // State and datapath registers; everything returns to an idle, closed
    // message on reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            crc       <= INIT_T;
            cnt       <= '0;
            shbuf     <= '0;
            last_flag <= 1'b0;
            msg_open  <= 1'b0;
        end else begin
            state     <= state_d;
            crc       <= crc_d;
            cnt       <= cnt_d;
            shbuf     <= shbuf_d;
            last_flag <= last_d;
            msg_open  <= open_d;
        end
    end

    // Next-state, datapath update and handshake outputs; CLEAR overrides all.
    always_comb begin
        state_d   = state;
        crc_d     = crc;
        cnt_d     = cnt;
        shbuf_d   = shbuf;
        last_d    = last_flag;
        open_d    = msg_open;
        IN_READY  = (state == IDLE);
        OUT_VALID = (state == DONE);

        case (state)
            IDLE: begin
                if (IN_VALID) begin
                    shbuf_d = IN_DATA;
                    last_d  = IN_LAST;
                    cnt_d   = '0;
                    state_d = SHIFT_DATA;
                    // First word of a message restarts the register.
                    if (!msg_open) begin
                        crc_d  = INIT_T;
                        open_d = 1'b1;
                    end
                end
            end
            SHIFT_DATA: begin
                crc_d   = lfsr_step(crc, shbuf[DATA_W-1]);
                shbuf_d = shbuf << 1;
                cnt_d   = cnt + CNT_W'(1);
                if (cnt == DATA_LAST) begin
                    cnt_d = '0;
                    if (!last_flag)
                        state_d = IDLE;
                    else if (AUGMENT != 0)
                        state_d = SHIFT_ZEROS;
                    else
                        state_d = DONE;
                end
            end
            SHIFT_ZEROS: begin
                crc_d = lfsr_step(crc, 1'b0);
                cnt_d = cnt + CNT_W'(1);
                if (cnt == ZERO_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                    open_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort: drop the message and any word offered in the same cycle.
        if (CLEAR) begin
            state_d = IDLE;
            crc_d   = INIT_T;
            cnt_d   = '0;
            last_d  = 1'b0;
            open_d  = 1'b0;
        end
    end

    // The register is frozen in DONE, so the result holds until accepted.
    assign OUT_CRC = (state == DONE) ? (crc ^ XOR_T) : '0;
    assign BUSY    = !((state == IDLE) && !msg_open);

endmodule
